rv32_decode_scoreboard: RTL and testbench
=========================================

# rv32_decode_scoreboard

Parametrised register scoreboard for the decode stage. It tracks how many long-latency writes (loads, multi-cycle mul/div, and any future unit) are in flight per architectural register. It stalls decode when a source operand, or a saturated destination, is still pending. It extends the fixed single-slot hazard check to N read ports, M write-back release ports and multiple outstanding writes per register. It sits beside the decode-stage hazard detection unit, and its `stall` is ORed into the decode stall.

## Interface
Parameters:
- `NUM_REGS`, 32: architectural registers tracked; address width `AW = $clog2(NUM_REGS)`.
- `NUM_READ`, 3: source-operand check ports (matches `CORE_RF_NUM_READ`).
- `NUM_WB`, 2: release ports, one per long-latency write-back path.
- `CNT_W`, 2: per-register counter width; max outstanding writes per register is `2**CNT_W - 1`.

Ports:
- `clk`  in  1  core clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `issue_valid`  in  1  decode presents an instruction this cycle.
- `issue_long`  in  1  the presented instruction writes `issue_rd` through a release port.
- `issue_rd`  in  AW  destination register.
- `flush`  in  1  jump or interrupt this cycle; the presented instruction is discarded.
- `rs_valid`  in  NUM_READ  the source port is used (`use_rs`).
- `rs_addr`  in  NUM_READ*AW  source register addresses, packed with port 0 at the LSBs.
- `release_valid`  in  NUM_WB  a long-latency result is written back this cycle.
- `release_rd`  in  NUM_WB*AW  register being released.
- `stall`  out  1  combinational; hold decode this cycle.
- `busy`  out  NUM_REGS  registered; bit r is set when the count for r is non-zero.
- `inflight`  out  AW+CNT_W  registered total of outstanding long writes.
- `underflow_err`  out  1  registered, sticky; a release arrived for a register whose count was zero.

## Operation
- State: `cnt[r]` of width CNT_W for r = 1..NUM_REGS-1. Register 0 has no counter and is never busy, never stalls and ignores releases.
- `src_hit[i]` = `rs_valid[i]` && `rs_addr[i] != 0` && `cnt[rs_addr[i]] != 0`.
- `sat_hit` = `issue_valid` && `issue_long` && `issue_rd != 0` && `cnt[issue_rd]` equals its maximum and no release for `issue_rd` is present this cycle.
- `stall` = `issue_valid` && (OR of `src_hit`, or `sat_hit`).
- `accept` = `issue_valid` && `!stall` && `!flush` && `issue_long` && `issue_rd != 0`.
- Next count per register: `cnt + accept_to_r - number_of_releases_to_r`. Two releases to the same register in one cycle decrement it by 2.
- A release that would take a count below 0 clamps the count at 0 and sets `underflow_err`. Only `reset` clears `underflow_err`.
- Issue and release to the same register in the same cycle leave the count unchanged.
- `flush` never cancels writes that are already counted; those ops always complete and release.
- `inflight` = the sum of all `cnt`. It is maintained incrementally, not by a combinational adder tree.

## Timing
- Reset (sync, `reset` high at posedge): all `cnt` = 0, `busy` = 0, `inflight` = 0, `underflow_err` = 0. `stall` is 0 during reset because all counts are 0.
- `stall` has zero-cycle latency from the inputs and registered counts; there is no flop on the stall path.
- An accepted issue becomes visible in `busy` and `inflight` one cycle later. A dependent instruction in the next cycle stalls.
- A release clears `busy` one cycle later. Same-cycle release behaviour is set by the macro below.
- `reset` asserted mid-operation drops all pending state. The pipeline is flushed by the same reset, so no releases arrive afterwards.

## Configuration
- `SCOREBOARD_RELEASE_BYPASS_EN` defined: `src_hit[i]` is suppressed when `cnt[rs_addr[i]]` equals the number of releases to that register this cycle. The write-back value is forwarded in the same cycle, so there is no stall bubble.
- Not defined: a source stalls until its registered count reads 0, which costs one extra cycle after the final release.

## Test plan
- Reset, then `rs_valid`=3'b001 with `rs_addr[0]`=5: `stall`=0, `busy`=0, `inflight`=0.
- Issue a long write to x5 at cycle 0, then a read of x5 at cycles 1..3, with a release of x5 at cycle 3:
  - with the macro: `stall`=1 in cycles 1–2 and 0 in cycle 3;
  - without the macro: `stall`=1 in cycles 1–3 and 0 in cycle 4;
  - `busy[5]` is 1 from cycle 1 to cycle 3.
- With `CNT_W`=2, issue three long writes to x7. A fourth issue with no release gives `stall`=1 (`sat_hit`) and `inflight`=3. The fourth issue accompanied by a release of x7 gives `stall`=0 and `inflight` stays 3.
- Issue to x9 with `flush`=1: no count change and `inflight`=0. Issue to x0 with `issue_long`=1: no count change and a read of x0 never stalls.
- Two simultaneous releases of x4 with `cnt[4]`=2: next cycle `cnt[4]`=0 and `busy[4]`=0.
- A release of x6 while `cnt[6]`=0: `underflow_err`=1 next cycle and it stays 1 until `reset`.

Source files
------------

// File: rtl/rv32_decode_scoreboard.sv
// Decode-stage register scoreboard: per-register counts of in-flight long writes.
// Optional same-cycle release forwarding: SCOREBOARD_RELEASE_BYPASS_EN.
module rv32_decode_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int NUM_READ = 3,
  parameter int NUM_WB   = 2,
  parameter int CNT_W    = 2,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     issue_valid,
  input  logic                     issue_long,
  input  logic [AW-1:0]            issue_rd,
  input  logic                     flush,
  input  logic [NUM_READ-1:0]      rs_valid,
  input  logic [NUM_READ*AW-1:0]   rs_addr,
  input  logic [NUM_WB-1:0]        release_valid,
  input  logic [NUM_WB*AW-1:0]     release_rd,
  output logic                     stall,
  output logic [NUM_REGS-1:0]      busy,
  output logic [AW+CNT_W-1:0]      inflight,
  output logic                     underflow_err
);

  localparam int RW = $clog2(NUM_WB + 1);
  localparam int SW = CNT_W + RW + 1;
  localparam int IW = AW + CNT_W;
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic [CNT_W-1:0]    cnt_q [NUM_REGS];
  logic [CNT_W-1:0]    cnt_d [NUM_REGS];
  logic [RW-1:0]       rel_n [NUM_REGS];
  logic [NUM_REGS-1:0] busy_d;
  logic [NUM_READ-1:0] src_hit;
  logic [IW-1:0]       inflight_d;
  logic [RW-1:0]       dec;
  logic                sat_hit;
  logic                accept;
  logic                uf_any;

  // releases per register this cycle; x0 never counts
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      rel_n[r] = '0;
      for (int k = 0; k < NUM_WB; k++) begin
        if (release_valid[k] && r != 0 &&
            release_rd[k*AW +: AW] == AW'(r))
          rel_n[r] = rel_n[r] + RW'(1);
      end
    end
  end

  always_comb begin
    logic [AW-1:0] a;
    a = '0;
    for (int i = 0; i < NUM_READ; i++) begin
      a = rs_addr[i*AW +: AW];
      src_hit[i] = rs_valid[i] && a != '0 &&
                   cnt_q[a] != '0;
`ifdef SCOREBOARD_RELEASE_BYPASS_EN
      if (SW'(cnt_q[a]) == SW'(rel_n[a]))
        src_hit[i] = 1'b0;
`endif
    end
  end

  assign sat_hit = issue_valid && issue_long &&
                   issue_rd != '0 &&
                   cnt_q[issue_rd] == CMAX &&
                   rel_n[issue_rd] == '0;

  assign stall  = issue_valid && ((|src_hit) || sat_hit);
  assign accept = issue_valid && !stall && !flush &&
                  issue_long && issue_rd != '0;

  always_comb begin
    logic [SW-1:0] tot;
    logic          acc;
    tot    = '0;
    acc    = 1'b0;
    uf_any = 1'b0;
    busy_d = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      acc = accept && issue_rd == AW'(r);
      tot = SW'(cnt_q[r]) + SW'(acc);
      if (tot < SW'(rel_n[r])) begin
        cnt_d[r] = '0;
        uf_any   = 1'b1;
      end else begin
        cnt_d[r] = CNT_W'(tot - SW'(rel_n[r]));
      end
      busy_d[r] = cnt_d[r] != '0;
    end
  end

  // a release only lowers the total if its register still had a count to give
  always_comb begin
    logic [AW-1:0] a;
    logic [RW-1:0] earlier;
    logic [SW-1:0] avail;
    a       = '0;
    earlier = '0;
    avail   = '0;
    dec     = '0;
    for (int k = 0; k < NUM_WB; k++) begin
      a       = release_rd[k*AW +: AW];
      earlier = '0;
      for (int j = 0; j < k; j++) begin
        if (release_valid[j] && release_rd[j*AW +: AW] == a)
          earlier = earlier + RW'(1);
      end
      avail = SW'(cnt_q[a]) +
              SW'(accept && issue_rd == a);
      if (release_valid[k] && a != '0 &&
          SW'(earlier) < avail)
        dec = dec + RW'(1);
    end
  end

  assign inflight_d = inflight + IW'(accept) - IW'(dec);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++)
        cnt_q[r] <= '0;
      busy          <= '0;
      inflight      <= '0;
      underflow_err <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++)
        cnt_q[r] <= cnt_d[r];
      busy          <= busy_d;
      inflight      <= inflight_d;
      underflow_err <= underflow_err | uf_any;
    end
  end

endmodule

// File: tb/tb_rv32_decode_scoreboard.sv
// Directed scoreboard bench for rv32_decode_scoreboard.
// Expectations are queued with the stimulus and popped at the sample point.
module tb_rv32_decode_scoreboard;
  localparam int AW = 5;

`ifdef SCOREBOARD_RELEASE_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          issue_valid;
  logic          issue_long;
  logic [AW-1:0] issue_rd;
  logic          flush;
  logic [2:0]    rs_valid;
  logic [14:0]   rs_addr;
  logic [1:0]    release_valid;
  logic [9:0]    release_rd;
  logic          stall;
  logic [31:0]   busy;
  logic [6:0]    inflight;
  logic          underflow_err;

  rv32_decode_scoreboard dut (
    .clk           (clk),
    .reset         (reset),
    .issue_valid   (issue_valid),
    .issue_long    (issue_long),
    .issue_rd      (issue_rd),
    .flush         (flush),
    .rs_valid      (rs_valid),
    .rs_addr       (rs_addr),
    .release_valid (release_valid),
    .release_rd    (release_rd),
    .stall         (stall),
    .busy          (busy),
    .inflight      (inflight),
    .underflow_err (underflow_err)
  );

  always #5 clk = ~clk;

  typedef enum logic [1:0] {K_STALL, K_BUSY, K_INFL, K_UF} kind_e;
  typedef struct {
    kind_e k;
    int    idx;
    int    val;
    string tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, expv);
    end
  endtask

  task automatic want(input kind_e k, input int idx, input int v,
                      input string tag);
    exp_t e;
    e.k = k; e.idx = idx; e.val = v; e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic sample();
    exp_t e;
    logic [31:0] obs;
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      obs = '0;
      case (e.k)
        K_STALL: obs = 32'(stall);
        K_BUSY:  obs = 32'(busy[e.idx]);
        K_INFL:  obs = 32'(inflight);
        K_UF:    obs = 32'(underflow_err);
        default: obs = '1;
      endcase
      chk(e.tag, obs, 32'(e.val));
    end
  endtask

  task automatic idle();
    issue_valid   = 1'b0;
    issue_long    = 1'b0;
    issue_rd      = '0;
    flush         = 1'b0;
    rs_valid      = '0;
    rs_addr       = '0;
    release_valid = '0;
    release_rd    = '0;
  endtask

  task automatic nxt();
    @(negedge clk);
    idle();
  endtask

  task automatic iss(input int rd, input bit lng);
    issue_valid = 1'b1;
    issue_long  = lng;
    issue_rd    = AW'(rd);
  endtask

  task automatic rd_port(input int p, input int a);
    rs_valid[p]          = 1'b1;
    rs_addr[p*AW +: AW]  = AW'(a);
  endtask

  task automatic rel(input int p, input int a);
    release_valid[p]        = 1'b1;
    release_rd[p*AW +: AW]  = AW'(a);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    nxt(); reset = 1'b1;
    nxt(); reset = 1'b1;
    nxt(); reset = 1'b0;

    // reset state with a read of x5
    iss(1, 1'b0); rd_port(0, 5);
    want(K_STALL, 0, 0, "rst_stall");
    want(K_BUSY, 5, 0, "rst_busy5");
    want(K_INFL, 0, 0, "rst_infl");
    want(K_UF, 0, 0, "rst_uf");
    sample();

    // long write to x5, dependent reads, release in cycle 3
    nxt(); iss(5, 1'b1);
    want(K_STALL, 0, 0, "x5_c0_stall");
    sample();
    nxt(); iss(1, 1'b0); rd_port(0, 5);
    want(K_STALL, 0, 1, "x5_c1_stall");
    want(K_BUSY, 5, 1, "x5_c1_busy");
    want(K_INFL, 0, 1, "x5_c1_infl");
    sample();
    nxt(); iss(1, 1'b0); rd_port(0, 5);
    want(K_STALL, 0, 1, "x5_c2_stall");
    want(K_BUSY, 5, 1, "x5_c2_busy");
    sample();
    nxt(); iss(1, 1'b0); rd_port(0, 5); rel(0, 5);
    want(K_STALL, 0, (BYP != 0) ? 0 : 1, "x5_c3_stall");
    want(K_BUSY, 5, 1, "x5_c3_busy");
    sample();
    nxt(); iss(1, 1'b0); rd_port(0, 5);
    want(K_STALL, 0, 0, "x5_c4_stall");
    want(K_BUSY, 5, 0, "x5_c4_busy");
    want(K_INFL, 0, 0, "x5_c4_infl");
    sample();

    // saturate x7
    for (int i = 0; i < 3; i++) begin
      nxt(); iss(7, 1'b1);
      want(K_STALL, 0, 0, "x7_fill_stall");
      want(K_INFL, 0, i, "x7_fill_infl");
      sample();
    end
    nxt(); iss(7, 1'b1);
    want(K_STALL, 0, 1, "x7_sat_stall");
    want(K_INFL, 0, 3, "x7_sat_infl");
    sample();
    nxt(); iss(7, 1'b1); rel(1, 7);
    want(K_STALL, 0, 0, "x7_satrel_stall");
    want(K_INFL, 0, 3, "x7_satrel_infl");
    sample();
    nxt(); rel(0, 7); rel(1, 7);
    want(K_INFL, 0, 3, "x7_hold_infl");
    want(K_BUSY, 7, 1, "x7_hold_busy");
    sample();
    nxt(); rel(0, 7);
    want(K_INFL, 0, 1, "x7_drain1_infl");
    sample();
    nxt();
    want(K_INFL, 0, 0, "x7_drain0_infl");
    want(K_BUSY, 7, 0, "x7_drain0_busy");
    want(K_UF, 0, 0, "x7_drain0_uf");
    sample();

    // flushed issue and x0 issue
    nxt(); iss(9, 1'b1); flush = 1'b1;
    want(K_STALL, 0, 0, "x9_flush_stall");
    sample();
    nxt(); iss(0, 1'b1);
    want(K_INFL, 0, 0, "x9_flush_infl");
    want(K_BUSY, 9, 0, "x9_flush_busy");
    sample();
    nxt(); iss(1, 1'b0);
    rd_port(0, 0); rd_port(1, 0); rd_port(2, 0);
    want(K_STALL, 0, 0, "x0_read_stall");
    want(K_INFL, 0, 0, "x0_issue_infl");
    want(K_BUSY, 0, 0, "x0_busy");
    sample();

    // read port 2 dependency on x3
    nxt(); iss(3, 1'b1);
    sample();
    nxt(); iss(1, 1'b0); rd_port(2, 3);
    want(K_STALL, 0, 1, "x3_p2_stall");
    sample();
    nxt(); rel(1, 3);
    sample();
    nxt(); iss(1, 1'b0); rd_port(2, 3);
    want(K_STALL, 0, 0, "x3_p2_free");
    want(K_INFL, 0, 0, "x3_infl");
    sample();

    // double release of x4
    nxt(); iss(4, 1'b1);
    sample();
    nxt(); iss(4, 1'b1);
    sample();
    nxt(); rel(0, 4); rel(1, 4);
    want(K_BUSY, 4, 1, "x4_busy_pre");
    want(K_INFL, 0, 2, "x4_infl_pre");
    sample();
    nxt();
    want(K_BUSY, 4, 0, "x4_busy_post");
    want(K_INFL, 0, 0, "x4_infl_post");
    want(K_UF, 0, 0, "x4_uf");
    sample();

    // release of x0 is ignored
    nxt(); rel(0, 0);
    sample();
    nxt();
    want(K_UF, 0, 0, "x0_rel_uf");
    sample();

    // underflow on x6, sticky until reset
    nxt(); rel(1, 6);
    sample();
    nxt(); iss(10, 1'b1);
    want(K_UF, 0, 1, "x6_uf_set");
    want(K_INFL, 0, 0, "x6_infl");
    sample();
    nxt();
    sample();
    nxt();
    want(K_UF, 0, 1, "x6_uf_sticky");
    want(K_BUSY, 10, 1, "x10_busy");
    want(K_INFL, 0, 1, "x10_infl");
    sample();

    // mid-operation reset
    nxt(); reset = 1'b1;
    sample();
    nxt(); reset = 1'b0; iss(1, 1'b0); rd_port(1, 10);
    want(K_UF, 0, 0, "rst2_uf");
    want(K_INFL, 0, 0, "rst2_infl");
    want(K_BUSY, 10, 0, "rst2_busy");
    want(K_STALL, 0, 0, "rst2_stall");
    sample();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
